// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side bus of the round-robin SRAM arbiter.
// slave = arbiter view, master = requesters plus SRAM view.
interface sram_arbiter_if #(
    parameter int data_width = 16,
    parameter int addr_width = 14,
    parameter int n_req      = 3
);
    logic [n_req-1:0]            req;
    logic [n_req-1:0]            req_we;
    logic [n_req*addr_width-1:0] req_addr;
    logic [n_req*data_width-1:0] req_wdata;
    logic [n_req-1:0]            ack;
    logic [data_width-1:0]       rdata;
    logic                        sram_read;
    logic                        sram_write;
    logic [addr_width-1:0]       sram_read_addr;
    logic [addr_width-1:0]       sram_write_addr;
    logic [data_width-1:0]       sram_data_in;
    logic [data_width-1:0]       sram_data_out;
    logic                        sram_read_ready;
    logic                        sram_write_ready;
    logic                        busy;
    logic                        error;

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        input  sram_data_out, sram_read_ready, sram_write_ready,
        output ack, rdata, sram_read, sram_write, sram_read_addr, sram_write_addr,
        output sram_data_in, busy, error
    );

    modport master (
        output req, req_we, req_addr, req_wdata,
        output sram_data_out, sram_read_ready, sram_write_ready,
        input  ack, rdata, sram_read, sram_write, sram_read_addr, sram_write_addr,
        input  sram_data_in, busy, error
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter giving n_req requesters single-word access to one SRAM.
// Optional macro SRAM_ARB_TIMEOUT_EN adds a WAIT watchdog of timeout_cycles.
module sram_arbiter #(
    parameter int data_width     = 16,
    parameter int addr_width     = 14,
    parameter int n_req          = 3,
    parameter int timeout_cycles = 255
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    localparam int IW = (n_req > 1) ? $clog2(n_req) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d, gnt_q, gnt_d;
    logic                  we_q;
    logic [addr_width-1:0] addr_q;
    logic [data_width-1:0] wdata_q;
    logic [data_width-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  rrdy_q, wrdy_q;
    logic [data_width-1:0] dout_q;
    logic                  latch;
    logic                  hit;
    logic [IW-1:0]         pick;
    logic                  match;

    // First asserting requester at or after rr_q, wrapping modulo n_req
    always_comb begin
        int idx;
        hit  = 1'b0;
        pick = '0;
        idx  = 0;
        for (int k = 0; k < n_req; k++) begin
            idx = (int'(rr_q) + k) % n_req;
            if (!hit && bus.req[idx]) begin
                hit  = 1'b1;
                pick = IW'(idx);
            end
        end
    end

    // SRAM completion and data are registered, giving the L+3 request-to-ack latency
    assign match = we_q ? wrdy_q : rrdy_q;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles + 1);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 cnt_q <= '0;
        else if (state_q == ISSUE)  cnt_q <= '0;
        else if (state_q == WAIT)   cnt_q <= cnt_q + 1'b1;
    end
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: if (hit) begin
                gnt_d   = pick;
                latch   = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (match) begin
                    if (!we_q) rdata_d = dout_q;
                    state_d = DONE;
                end
`ifdef SRAM_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(timeout_cycles - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                rr_d    = (gnt_q == IW'(n_req - 1)) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rrdy_q  <= 1'b0;
            wrdy_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rrdy_q  <= bus.sram_read_ready;
            wrdy_q  <= bus.sram_write_ready;
            dout_q  <= bus.sram_data_out;
            if (latch) begin
                we_q    <= bus.req_we[pick];
                addr_q  <= bus.req_addr[pick*addr_width +: addr_width];
                wdata_q <= bus.req_wdata[pick*data_width +: data_width];
            end
        end
    end

    assign bus.ack             = (state_q == DONE) ? (n_req'(1) << gnt_q) : '0;
    assign bus.sram_read       = (state_q == ISSUE) && !we_q;
    assign bus.sram_write      = (state_q == ISSUE) && we_q;
    assign bus.sram_read_addr  = addr_q;
    assign bus.sram_write_addr = addr_q;
    assign bus.sram_data_in    = wdata_q;
    assign bus.rdata           = rdata_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.error           = err_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: read, write, contention, wrap, reset and watchdog.
module tb_sram_arbiter;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec = 0;
    int   errs = 0;

    // SRAM responder controls
    bit              auto_en = 1'b0;
    int              lat = 0;
    int              cd = -1;
    bit              cd_w = 1'b0;
    logic [DW-1:0]   rd_val = '0;

    sram_arbiter_if #(.data_width(DW), .addr_width(AW), .n_req(NR)) sif();

    sram_arbiter #(.data_width(DW), .addr_width(AW), .n_req(NR), .timeout_cycles(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    // Answers each strobe with a one-cycle ready lat cycles later
    always @(negedge clk) begin
        sif.sram_read_ready  = 1'b0;
        sif.sram_write_ready = 1'b0;
        if (auto_en) begin
            if (sif.sram_read || sif.sram_write) begin
                cd   = lat;
                cd_w = sif.sram_write;
            end else if (cd > 0) begin
                cd = cd - 1;
            end
            if (cd == 0) begin
                if (cd_w) sif.sram_write_ready = 1'b1;
                else begin
                    sif.sram_read_ready = 1'b1;
                    sif.sram_data_out   = rd_val;
                end
                cd = -1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic collect(input int n, input int budget, output int ord[4],
                           output int got, output int first_cyc, output bit multi);
        got = 0; multi = 1'b0; first_cyc = -1;
        for (int i = 0; i < 4; i++) ord[i] = -1;
        for (int c = 1; c <= budget && got < n; c++) begin
            @(negedge clk);
            if ($countones(sif.ack) > 1 || (sif.sram_read && sif.sram_write)) multi = 1'b1;
            for (int i = 0; i < NR; i++) if (sif.ack[i]) begin
                if (got < 4) ord[got] = i;
                if (got == 0) first_cyc = c;
                got++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [63:0] obs;
        rst_n = 1'b0;
        tick(); tick();
        obs = {sif.ack, sif.sram_read, sif.sram_write, sif.sram_read_addr, sif.sram_write_addr,
               sif.sram_data_in, sif.rdata, sif.busy, sif.error};
        vec++;
        if (obs !== 64'd0) begin
            errs++; $display("FAIL reset_outputs got %h exp 0", obs);
        end
        rst_n = 1'b1;
        tick();
        vec++;
        if (sif.busy !== 1'b0) begin
            errs++; $display("FAIL reset_idle busy got %b exp 0", sif.busy);
        end
    endtask

    task automatic test_single_read();
        int strobes = 0;
        int ack_cyc = -1;
        auto_en = 1'b1; lat = 2; rd_val = 16'h1234;
        sif.req_we = '0;
        sif.req_addr[0*AW +: AW] = 14'h0010;
        sif.req = 3'b001;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            tick();
            if (sif.sram_read) begin
                strobes++;
                vec++;
                if (sif.sram_read_addr !== 14'h0010) begin
                    errs++; $display("FAIL read_addr got %h exp 0010", sif.sram_read_addr);
                end
            end
            if (sif.ack[0]) begin
                ack_cyc = c;
                sif.req = '0;
            end
        end
        vec++;
        if (strobes !== 1) begin errs++; $display("FAIL read_strobes got %0d exp 1", strobes); end
        vec++;
        if (ack_cyc !== 5) begin errs++; $display("FAIL read_latency got %0d exp 5", ack_cyc); end
        vec++;
        if (sif.rdata !== 16'h1234) begin errs++; $display("FAIL read_rdata got %h exp 1234", sif.rdata); end
        tick();
    endtask

    task automatic test_write();
        bit saw_read = 1'b0;
        bit acked = 1'b0;
        auto_en = 1'b1; lat = 1;
        sif.req_we = 3'b100;
        sif.req_addr[2*AW +: AW]  = 14'h3FFF;
        sif.req_wdata[2*DW +: DW] = 16'hBEEF;
        sif.req = 3'b100;
        tick();
        // Granted: scramble the requester's inputs and drop req; access must be unaffected
        sif.req_addr[2*AW +: AW]  = '0;
        sif.req_wdata[2*DW +: DW] = '0;
        sif.req_we = '0;
        sif.req = '0;
        vec++;
        if (sif.sram_write !== 1'b1) begin errs++; $display("FAIL write_strobe got %b exp 1", sif.sram_write); end
        vec++;
        if (sif.sram_write_addr !== 14'h3FFF) begin
            errs++; $display("FAIL write_addr got %h exp 3fff", sif.sram_write_addr);
        end
        vec++;
        if (sif.sram_data_in !== 16'hBEEF) begin
            errs++; $display("FAIL write_data got %h exp beef", sif.sram_data_in);
        end
        if (sif.sram_read) saw_read = 1'b1;
        for (int c = 0; c < 20 && !acked; c++) begin
            tick();
            if (sif.sram_read) saw_read = 1'b1;
            if (sif.ack === 3'b100) acked = 1'b1;
        end
        vec++;
        if (acked !== 1'b1) begin errs++; $display("FAIL write_ack got %b exp 1", acked); end
        vec++;
        if (saw_read !== 1'b0) begin errs++; $display("FAIL write_no_read got %b exp 0", saw_read); end
        vec++;
        if (sif.rdata !== 16'h1234) begin errs++; $display("FAIL write_rdata_kept got %h exp 1234", sif.rdata); end
        tick();
    endtask

    task automatic test_contention();
        int ord[4]; int got; int fc; bit multi;
        do_reset();
        auto_en = 1'b1; lat = 0; rd_val = 16'h0777;
        sif.req_we = '0;
        sif.req = 3'b111;
        collect(4, 40, ord, got, fc, multi);
        sif.req = '0;
        vec++;
        if (got !== 4) begin errs++; $display("FAIL contention_count got %0d exp 4", got); end
        vec++;
        if ({ord[0], ord[1], ord[2], ord[3]} !== {32'd0, 32'd1, 32'd2, 32'd0}) begin
            errs++; $display("FAIL contention_order got %0d %0d %0d %0d exp 0 1 2 0", ord[0], ord[1], ord[2], ord[3]);
        end
        vec++;
        if (multi !== 1'b0) begin errs++; $display("FAIL contention_onehot got %b exp 0", multi); end
        vec++;
        if (fc !== 3) begin errs++; $display("FAIL min_latency got %0d exp 3", fc); end
        tick();
    endtask

    task automatic test_wrap();
        int ord[4]; int got; int fc; bit multi;
        sif.req = 3'b100;
        collect(1, 20, ord, got, fc, multi);
        sif.req = 3'b101;
        vec++;
        if (ord[0] !== 2) begin errs++; $display("FAIL wrap_first got %0d exp 2", ord[0]); end
        collect(2, 30, ord, got, fc, multi);
        sif.req = '0;
        vec++;
        if ({ord[0], ord[1]} !== {32'd0, 32'd2}) begin
            errs++; $display("FAIL wrap_order got %0d %0d exp 0 2", ord[0], ord[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int ord[4]; int got; int fc; bit multi;
        logic [63:0] obs;
        int stray = 0;
        auto_en = 1'b0;
        sif.req_we = '0;
        sif.req_addr[1*AW +: AW] = 14'h0ABC;
        sif.req = 3'b010;
        tick(); tick();
        vec++;
        if (sif.busy !== 1'b1) begin errs++; $display("FAIL mid_wait_busy got %b exp 1", sif.busy); end
        #2 rst_n = 1'b0;
        #1;
        obs = {sif.ack, sif.sram_read, sif.sram_write, sif.sram_read_addr, sif.sram_write_addr,
               sif.sram_data_in, sif.rdata, sif.busy, sif.error};
        vec++;
        if (obs !== 64'd0) begin errs++; $display("FAIL async_reset got %h exp 0", obs); end
        sif.req = '0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sif.ack !== '0) stray++;
        end
        vec++;
        if (stray !== 0) begin errs++; $display("FAIL no_ack_after_reset got %0d exp 0", stray); end
        auto_en = 1'b1; lat = 0; rd_val = 16'h5A5A;
        sif.req = 3'b110;
        collect(1, 20, ord, got, fc, multi);
        sif.req = '0;
        vec++;
        if (ord[0] !== 1) begin errs++; $display("FAIL post_reset_grant got %0d exp 1", ord[0]); end
        vec++;
        if (sif.rdata !== 16'h5A5A) begin errs++; $display("FAIL post_reset_rdata got %h exp 5a5a", sif.rdata); end
        tick();
    endtask

    task automatic test_timeout();
        auto_en = 1'b0;
        sif.req_we = '0;
        sif.req = 3'b001;
`ifdef SRAM_ARB_TIMEOUT_EN
        begin
            int ord[4]; int got; int fc; bit multi;
            collect(1, 30, ord, got, fc, multi);
            sif.req = '0;
            vec++;
            if (ord[0] !== 0) begin errs++; $display("FAIL timeout_grant got %0d exp 0", ord[0]); end
            vec++;
            if (fc !== 10) begin errs++; $display("FAIL timeout_cycle got %0d exp 10", fc); end
            vec++;
            if (sif.error !== 1'b1) begin errs++; $display("FAIL timeout_error got %b exp 1", sif.error); end
            vec++;
            if (sif.rdata !== 16'h0000) begin errs++; $display("FAIL timeout_rdata got %h exp 0", sif.rdata); end
            tick();
        end
`else
        begin
            int acks = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (sif.ack !== '0) acks++;
            end
            vec++;
            if (acks !== 0) begin errs++; $display("FAIL no_timeout_ack got %0d exp 0", acks); end
            vec++;
            if (sif.busy !== 1'b1) begin errs++; $display("FAIL no_timeout_busy got %b exp 1", sif.busy); end
            vec++;
            if (sif.error !== 1'b0) begin errs++; $display("FAIL no_timeout_error got %b exp 0", sif.error); end
            sif.req = '0;
            do_reset();
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        sif.req = '0;
        sif.req_we = '0;
        sif.req_addr = '0;
        sif.req_wdata = '0;
        sif.sram_data_out = '0;
        sif.sram_read_ready = 1'b0;
        sif.sram_write_ready = 1'b0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_wrap();
        test_reset_mid_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
